// File: rtl/multi_channel_fifo_if.sv
// rtl/multi_channel_fifo_if.sv - lane-packed loader/array-edge bundle for multi_channel_fifo
interface multi_channel_fifo_if #(
    parameter int NCH    = 4,
    parameter int DEPTH  = 8,
    parameter int DWIDTH = 16
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic                  flush_i;
    logic [NCH-1:0]        wr_en_i;
    logic [NCH*DWIDTH-1:0] din_i;
    logic [NCH-1:0]        rd_en_i;
    logic [NCH-1:0]        mark_i;
    logic [NCH-1:0]        rewind_i;
    logic [NCH-1:0]        release_i;
    logic [NCH*DWIDTH-1:0] dout_o;
    logic [NCH-1:0]        dout_valid_o;
    logic [NCH-1:0]        full_o;
    logic [NCH-1:0]        empty_o;
    logic [NCH-1:0]        almost_full_o;
    logic [NCH-1:0]        almost_empty_o;
    logic [NCH*CW-1:0]     count_o;
    logic [NCH-1:0]        overflow_o;
    logic [NCH-1:0]        underflow_o;

    // Loader / array side: drives requests, observes data and status
    modport master (
        output flush_i, wr_en_i, din_i, rd_en_i, mark_i, rewind_i, release_i,
        input  dout_o, dout_valid_o, full_o, empty_o, almost_full_o,
               almost_empty_o, count_o, overflow_o, underflow_o
    );

    // FIFO side
    modport slave (
        input  flush_i, wr_en_i, din_i, rd_en_i, mark_i, rewind_i, release_i,
        output dout_o, dout_valid_o, full_o, empty_o, almost_full_o,
               almost_empty_o, count_o, overflow_o, underflow_o
    );
endinterface

// File: rtl/multi_channel_fifo.sv
// rtl/multi_channel_fifo.sv - NCH independent FIFO lanes with occupancy flags and mark/rewind replay
module multi_channel_fifo #(
    parameter int NCH       = 4,
    parameter int DEPTH     = 8,
    parameter int DWIDTH    = 16,
    parameter int AFULL_TH  = DEPTH - 2,
    parameter int AEMPTY_TH = 2
) (
    input  logic               clk,
    input  logic               rstn,
    multi_channel_fifo_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;

    for (genvar g = 0; g < NCH; g++) begin : g_lane
        logic [DWIDTH-1:0] mem_q [DEPTH];
        logic [PW-1:0]     wptr_q, wptr_d;
        logic [PW-1:0]     rptr_q, rptr_d;
        logic [PW-1:0]     mptr_q, mptr_d;
        logic              mact_q, mact_d;
        logic [DWIDTH-1:0] dout_q, dout_d;
        logic              dv_q, dv_d;
        logic              ovf_q, ovf_d;
        logic              udf_q, udf_d;
        logic              mem_we;
        logic [PW-1:0]     base;
        logic [PW-1:0]     wcount;
        logic [PW-1:0]     count;
        logic              full;
        logic              empty;
        logic [DWIDTH-1:0] din_l;

        assign din_l  = bus.din_i[g*DWIDTH +: DWIDTH];

        // Retention starts at the replay point while a mark is held, so
        // marked entries count against capacity until released.
        assign base   = mact_q ? mptr_q : rptr_q;
        assign wcount = wptr_q - base;
        assign count  = wptr_q - rptr_q;
        assign full   = (wcount == PW'(DEPTH));
        assign empty  = (wptr_q == rptr_q);

        // Next-state: flush over everything, then rewind over mark/release/read;
        // write acceptance uses start-of-cycle flags only.
        always_comb begin
            wptr_d = wptr_q;
            rptr_d = rptr_q;
            mptr_d = mptr_q;
            mact_d = mact_q;
            dout_d = dout_q;
            dv_d   = 1'b0;
            ovf_d  = ovf_q;
            udf_d  = udf_q;
            mem_we = 1'b0;
            if (bus.flush_i) begin
                wptr_d = '0;
                rptr_d = '0;
                mptr_d = '0;
                mact_d = 1'b0;
                ovf_d  = 1'b0;
                udf_d  = 1'b0;
            end else begin
                if (bus.wr_en_i[g]) begin
                    if (!full) begin
                        mem_we = 1'b1;
                        wptr_d = wptr_q + PW'(1);
                    end else begin
                        ovf_d = 1'b1;
                    end
                end
                if (bus.rewind_i[g] && mact_q) begin
                    rptr_d = mptr_q;
                end else begin
                    if (bus.mark_i[g]) begin
                        mptr_d = rptr_q;
                        mact_d = 1'b1;
                    end else if (bus.release_i[g]) begin
                        mact_d = 1'b0;
                    end
                    if (bus.rd_en_i[g]) begin
                        if (!empty) begin
                            dout_d = mem_q[rptr_q[AW-1:0]];
                            rptr_d = rptr_q + PW'(1);
                            dv_d   = 1'b1;
                        end else begin
                            udf_d = 1'b1;
                        end
                    end
                end
            end
        end

        // Lane state registers
        always_ff @(posedge clk or negedge rstn) begin
            if (!rstn) begin
                wptr_q <= '0;
                rptr_q <= '0;
                mptr_q <= '0;
                mact_q <= 1'b0;
                dout_q <= '0;
                dv_q   <= 1'b0;
                ovf_q  <= 1'b0;
                udf_q  <= 1'b0;
            end else begin
                wptr_q <= wptr_d;
                rptr_q <= rptr_d;
                mptr_q <= mptr_d;
                mact_q <= mact_d;
                dout_q <= dout_d;
                dv_q   <= dv_d;
                ovf_q  <= ovf_d;
                udf_q  <= udf_d;
            end
        end

        // Storage array, deliberately left unreset
        always_ff @(posedge clk) begin
            if (mem_we) begin
                mem_q[wptr_q[AW-1:0]] <= din_l;
            end
        end

        assign bus.dout_o[g*DWIDTH +: DWIDTH] = dout_q;
        assign bus.dout_valid_o[g]            = dv_q;
        assign bus.full_o[g]                  = full;
        assign bus.empty_o[g]                 = empty;
        assign bus.almost_full_o[g]           = (wcount >= PW'(AFULL_TH));
        assign bus.almost_empty_o[g]          = (count <= PW'(AEMPTY_TH));
        assign bus.count_o[g*PW +: PW]        = count;
        assign bus.overflow_o[g]              = ovf_q;
        assign bus.underflow_o[g]             = udf_q;
    end
endmodule

// File: tb/tb_multi_channel_fifo.sv
// tb/tb_multi_channel_fifo.sv - self-checking bench for multi_channel_fifo
module tb_multi_channel_fifo;
    localparam int NCH    = 4;
    localparam int DEPTH  = 8;
    localparam int DWIDTH = 16;
    localparam int CW     = $clog2(DEPTH) + 1;
    localparam int AFT    = DEPTH - 2;
    localparam int AET    = 2;

    logic clk = 1'b0;
    logic rstn = 1'b0;
    always #5 clk = ~clk;

    multi_channel_fifo_if #(.NCH(NCH), .DEPTH(DEPTH), .DWIDTH(DWIDTH)) bus ();

    multi_channel_fifo #(.NCH(NCH), .DEPTH(DEPTH), .DWIDTH(DWIDTH)) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus.slave)
    );

    int n_vec = 0;
    int n_err = 0;

    // Reference: per lane, the retained words from the replay base onward,
    // plus how many of them have already been read out.
    logic [DWIDTH-1:0] mq [NCH][$];
    int                roff [NCH];
    bit                mact [NCH];
    logic [DWIDTH-1:0] mdout [NCH];
    bit                mdv [NCH];
    bit                movf [NCH];
    bit                mudf [NCH];

    task automatic check(input string name, input int lane, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s lane%0d: got 0x%0h expected 0x%0h at %0t", name, lane, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < NCH; i++) begin
            mq[i].delete();
            roff[i] = 0; mact[i] = 0; mdout[i] = '0;
            mdv[i] = 0; movf[i] = 0; mudf[i] = 0;
        end
    endtask

    task automatic model_step();
        for (int i = 0; i < NCH; i++) begin
            int  sz;
            bit  f0, e0, wacc;
            if (bus.flush_i) begin
                mq[i].delete();
                roff[i] = 0; mact[i] = 0; mdv[i] = 0; movf[i] = 0; mudf[i] = 0;
            end else begin
                sz   = mq[i].size();
                f0   = (sz == DEPTH);
                e0   = (roff[i] == sz);
                wacc = bus.wr_en_i[i] && !f0;
                if (bus.wr_en_i[i] && f0) movf[i] = 1;
                mdv[i] = 0;
                if (bus.rewind_i[i] && mact[i]) begin
                    roff[i] = 0;
                end else begin
                    if (bus.mark_i[i] || bus.release_i[i]) begin
                        for (int k = 0; k < roff[i]; k++) void'(mq[i].pop_front());
                        roff[i] = 0;
                        mact[i] = bus.mark_i[i];
                    end
                    if (bus.rd_en_i[i]) begin
                        if (!e0) begin
                            mdout[i] = mq[i][roff[i]];
                            if (mact[i]) roff[i]++;
                            else void'(mq[i].pop_front());
                            mdv[i] = 1;
                        end else begin
                            mudf[i] = 1;
                        end
                    end
                end
                if (wacc) mq[i].push_back(bus.din_i[i*DWIDTH +: DWIDTH]);
            end
        end
    endtask

    task automatic compare_all();
        for (int i = 0; i < NCH; i++) begin
            int c, w;
            w = mq[i].size();
            c = w - roff[i];
            check("dout",   i, 32'(bus.dout_o[i*DWIDTH +: DWIDTH]), 32'(mdout[i]));
            check("dv",     i, 32'(bus.dout_valid_o[i]), 32'(mdv[i]));
            check("full",   i, 32'(bus.full_o[i]), 32'(w == DEPTH));
            check("empty",  i, 32'(bus.empty_o[i]), 32'(c == 0));
            check("afull",  i, 32'(bus.almost_full_o[i]), 32'(w >= AFT));
            check("aempty", i, 32'(bus.almost_empty_o[i]), 32'(c <= AET));
            check("count",  i, 32'(bus.count_o[i*CW +: CW]), 32'(c));
            check("ovf",    i, 32'(bus.overflow_o[i]), 32'(movf[i]));
            check("udf",    i, 32'(bus.underflow_o[i]), 32'(mudf[i]));
        end
    endtask

    task automatic idle();
        bus.flush_i = 0; bus.wr_en_i = '0; bus.rd_en_i = '0; bus.din_i = '0;
        bus.mark_i = '0; bus.rewind_i = '0; bus.release_i = '0;
    endtask

    task automatic cycle();
        @(posedge clk);
        model_step();
        @(negedge clk);
        compare_all();
    endtask

    task automatic put(input int lane, input logic [DWIDTH-1:0] d);
        bus.wr_en_i[lane] = 1'b1;
        bus.din_i[lane*DWIDTH +: DWIDTH] = d;
    endtask

    task automatic do_flush();
        idle(); bus.flush_i = 1; cycle(); idle();
    endtask

    typedef struct {
        bit          wr;
        bit          rd;
        logic [15:0] din;
        bit          full;
        bit          empty;
        int          count;
        logic [15:0] dout;
        bit          dv;
        bit          ovf;
        bit          udf;
    } vec_t;

    vec_t tbl [18];
    logic [15:0] want;
    int          got;

    initial begin
        // Lane-0 fill/overflow/drain/underflow table; values follow directly
        // from DEPTH=8 and the 0x0001.. data pattern.
        for (int k = 0; k < 8; k++)
            tbl[k] = '{1, 0, 16'(k + 1), k == 7, 0, k + 1, 16'h0, 0, 0, 0};
        tbl[8] = '{1, 0, 16'h0009, 1, 0, 8, 16'h0, 0, 1, 0};
        for (int k = 0; k < 8; k++)
            tbl[9 + k] = '{0, 1, 16'h0, 0, k == 7, 7 - k, 16'(k + 1), 1, 1, 0};
        tbl[17] = '{0, 1, 16'h0, 0, 1, 0, 16'h0008, 0, 1, 1};

        idle();
        model_reset();
        #12;
        compare_all();
        check("rst_count0", 0, 32'(bus.count_o[CW-1:0]), 32'd0);
        check("rst_empty",  0, 32'(bus.empty_o), 32'hF);
        @(negedge clk);
        rstn = 1;

        for (int v = 0; v < 18; v++) begin
            idle();
            bus.wr_en_i[0] = tbl[v].wr;
            bus.rd_en_i[0] = tbl[v].rd;
            bus.din_i[15:0] = tbl[v].din;
            cycle();
            check("t_full",  v, 32'(bus.full_o[0]), 32'(tbl[v].full));
            check("t_empty", v, 32'(bus.empty_o[0]), 32'(tbl[v].empty));
            check("t_count", v, 32'(bus.count_o[CW-1:0]), 32'(tbl[v].count));
            check("t_dout",  v, 32'(bus.dout_o[15:0]), 32'(tbl[v].dout));
            check("t_dv",    v, 32'(bus.dout_valid_o[0]), 32'(tbl[v].dv));
            check("t_ovf",   v, 32'(bus.overflow_o[0]), 32'(tbl[v].ovf));
            check("t_udf",   v, 32'(bus.underflow_o[0]), 32'(tbl[v].udf));
            check("t_others_empty", v, 32'(bus.empty_o[3:1]), 32'h7);
        end

        // Mark on first read, rewind, replay; retention keeps lane full after reads
        do_flush();
        for (int k = 1; k <= 4; k++) begin idle(); put(0, 16'(k)); cycle(); end
        for (int pass = 0; pass < 2; pass++) begin
            for (int k = 1; k <= 4; k++) begin
                idle(); bus.rd_en_i[0] = 1; bus.mark_i[0] = (pass == 0 && k == 1);
                cycle();
                check("rp_dout", pass, 32'(bus.dout_o[15:0]), 32'(k));
                check("rp_dv",   pass, 32'(bus.dout_valid_o[0]), 32'd1);
            end
            check("rp_full", pass, 32'(bus.full_o[0]), 32'd0);
            if (pass == 0) begin
                idle(); bus.rewind_i[0] = 1; bus.rd_en_i[0] = 1; cycle();
                check("rew_dv",  0, 32'(bus.dout_valid_o[0]), 32'd0);
                check("rew_udf", 0, 32'(bus.underflow_o[0]), 32'd0);
                check("rew_cnt", 0, 32'(bus.count_o[CW-1:0]), 32'd4);
            end
        end
        for (int k = 5; k <= 8; k++) begin idle(); put(0, 16'(k)); cycle(); end
        check("mk_full",  0, 32'(bus.full_o[0]), 32'd1);
        check("mk_count", 0, 32'(bus.count_o[CW-1:0]), 32'd4);
        idle(); bus.release_i[0] = 1; cycle();
        check("rel_full",  0, 32'(bus.full_o[0]), 32'd0);
        check("rel_count", 0, 32'(bus.count_o[CW-1:0]), 32'd4);

        // Full lane 1 with read+write; empty lane 2 with read+write
        do_flush();
        for (int k = 1; k <= 8; k++) begin idle(); put(1, 16'(16'h0100 + k)); cycle(); end
        idle();
        put(1, 16'hDEAD); bus.rd_en_i[1] = 1;
        put(2, 16'h0055); bus.rd_en_i[2] = 1;
        cycle();
        check("fb_dout",  1, 32'(bus.dout_o[31:16]), 32'h0101);
        check("fb_ovf",   1, 32'(bus.overflow_o[1]), 32'd1);
        check("fb_count", 1, 32'(bus.count_o[2*CW-1:CW]), 32'd7);
        check("eb_dv",    2, 32'(bus.dout_valid_o[2]), 32'd0);
        check("eb_udf",   2, 32'(bus.underflow_o[2]), 32'd1);
        check("eb_count", 2, 32'(bus.count_o[3*CW-1:2*CW]), 32'd1);
        idle(); bus.rd_en_i[2] = 1; cycle();
        check("eb_dout",  2, 32'(bus.dout_o[47:32]), 32'h0055);

        // Async reset mid-stream, with writes pending
        idle(); put(3, 16'h7777); bus.rd_en_i[1] = 1;
        #2 rstn = 0;
        #1 model_reset();
        compare_all();
        check("ar_count1", 1, 32'(bus.count_o[2*CW-1:CW]), 32'd0);
        @(negedge clk);
        idle(); rstn = 1;

        // Flush with wr_en/rd_en high stores nothing and clears stickies
        for (int k = 1; k <= 3; k++) begin idle(); put(0, 16'(k)); put(2, 16'(k)); cycle(); end
        idle(); bus.rd_en_i = 4'hF; cycle();
        idle(); bus.flush_i = 1; bus.rd_en_i = 4'hF;
        for (int i = 0; i < NCH; i++) put(i, 16'hBEEF);
        cycle();
        check("fl_count", 0, 32'(bus.count_o), 32'd0);
        check("fl_dv",    0, 32'(bus.dout_valid_o), 32'd0);
        check("fl_udf",   0, 32'(bus.underflow_o), 32'd0);
        check("fl_dout0", 0, 32'(bus.dout_o[15:0]), 32'h0001);

        // Wrap: 20 words through lane 3's 8 entries
        want = 16'h1000; got = 0;
        for (int c = 0; c < 22; c++) begin
            idle();
            if (c < 20) put(3, 16'(16'h1000 + c));
            bus.rd_en_i[3] = (c >= 1 && c <= 20);
            cycle();
            if (bus.dout_valid_o[3]) begin
                check("wrap_dout", 3, 32'(bus.dout_o[63:48]), 32'(want));
                want++; got++;
            end
        end
        check("wrap_n", 3, 32'(got), 32'd20);

        // Randomised traffic against the reference
        do_flush();
        for (int c = 0; c < 1500; c++) begin
            idle();
            bus.flush_i = ($urandom_range(0, 199) == 0);
            for (int i = 0; i < NCH; i++) begin
                bus.wr_en_i[i]   = ($urandom_range(0, 99) < 50);
                bus.rd_en_i[i]   = ($urandom_range(0, 99) < 45);
                bus.mark_i[i]    = ($urandom_range(0, 99) < 5);
                bus.rewind_i[i]  = ($urandom_range(0, 99) < 4);
                bus.release_i[i] = ($urandom_range(0, 99) < 7);
                bus.din_i[i*DWIDTH +: DWIDTH] = 16'($urandom);
            end
            cycle();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/multi_channel_fifo.md
Name: multi_channel_fifo

Overview:
Parametrised single-clock, multi-channel FIFO. It is the successor to the per-column feeder buffer that feeds activations and weights into the systolic array.
Adds four things over the previous buffer: NCH independent lanes, full-depth occupancy (no sacrificed slot), occupancy counts with almost-full/almost-empty flags, and mark/rewind replay so one tile can be re-streamed for weight reuse without rewriting.
Sits between the DMA/loader and the array edge, one lane per array row or column.

Parameters:
NCH, 4, number of independent lanes
DEPTH, 8, entries per lane; power of two, >=2
DWIDTH, 16, data width per lane
AFULL_TH, DEPTH-2, almost_full[i] asserted when wcount[i] >= AFULL_TH
AEMPTY_TH, 2, almost_empty[i] asserted when count[i] <= AEMPTY_TH

Ports:
clk  input  1  single clock, rising edge
rstn  input  1  asynchronous active-low reset
flush  input  1  synchronous clear of all lanes
wr_en  input  NCH  per-lane write request
din  input  NCH*DWIDTH  write data; lane i at [i*DWIDTH +: DWIDTH]
rd_en  input  NCH  per-lane read request
dout  output  NCH*DWIDTH  registered read data, lane-packed
dout_valid  output  NCH  dout lane updated this cycle
mark  input  NCH  capture current read pointer as replay point
rewind  input  NCH  restore read pointer to replay point
release  input  NCH  drop replay point
full  output  NCH  lane cannot accept write
empty  output  NCH  lane has no readable entry
almost_full  output  NCH  see AFULL_TH
almost_empty  output  NCH  see AEMPTY_TH
count  output  NCH*($clog2(DEPTH)+1)  readable entries per lane (wptr-rptr)
overflow  output  NCH  sticky: write attempted while full
underflow  output  NCH  sticky: read attempted while empty

Behaviour:
- Pointers: $clog2(DEPTH)+1 bits with a wrap bit. All DEPTH entries are usable.
- Per-lane retention base: base = mark_active ? mark_ptr : rptr. wcount = wptr - base.
- full = (wcount == DEPTH); empty = (wptr == rptr); count = wptr - rptr.
- All flags are combinational from registered pointers.
- Reset (rstn low, async): all pointers 0, mark_active 0, dout 0, dout_valid 0, overflow 0, underflow 0. Memory contents are not reset.
- Write: wr_en[i] & !full[i] -> mem[wptr] <= din lane, wptr++.
  - wr_en while full: no write, overflow[i] <= 1.
- Read: rd_en[i] & !empty[i] -> dout lane <= mem[rptr], rptr++, dout_valid[i] <= 1 next cycle. Latency is 1 cycle.
  - Otherwise dout_valid[i] <= 0 and dout holds its value.
  - rd_en while empty sets underflow[i].
- Simultaneous read and write are evaluated on start-of-cycle flags:
  - Full lane: read accepted, write rejected (overflow set).
  - Empty lane: write accepted, read rejected (underflow set). There is no write-to-read bypass.
  - Both accepted: count unchanged.
- Priority per lane, same cycle: flush > rewind > mark > read.
  - rewind: rptr <= mark_ptr; any rd_en that cycle is ignored and does not set underflow; dout_valid 0 next cycle.
  - rewind with no mark_active: no-op.
  - mark with rd_en: mark_ptr captures rptr before increment, so the word being read is included in replay. mark_active <= 1.
  - mark while already marked: re-marks at the current rptr.
  - release: mark_active <= 0; entries behind rptr are freed the same cycle.
  - release together with mark: mark wins.
  - Writes proceed independently of mark/rewind/release in the same cycle.
- Replay guarantee: while mark_active, entries from mark_ptr to wptr are never overwritten; full is asserted against mark_ptr.
- flush: all lanes' pointers 0, mark_active 0, dout_valid 0, overflow/underflow cleared; wr_en and rd_en that cycle are ignored. dout holds.
- Wrap: pointer arithmetic is modulo 2*DEPTH; memory index uses the low $clog2(DEPTH) bits.
- Lanes are fully independent; one lane full or empty has no effect on the others.

Test Plan:
- Reset then write lane0 with 0x0001..0x0008 (DEPTH=8) -> full[0]=1 after the 8th write, count[0]=8, other lanes empty=1; 9th write sets overflow[0]=1 and data is unchanged.
- Read 8 entries back-to-back -> dout lane0 = 0x0001..0x0008 one cycle after each rd_en, dout_valid high 8 cycles, empty[0]=1 after; extra read sets underflow[0]=1 and dout holds 0x0008.
- Fill 4 words, mark with the first rd_en, read 4, rewind, read 4 -> sequence 0x0001..0x0004 twice; full[0] reflects 4 retained entries (wcount=4) until release.
- With mark_active, write 8 words total -> full[0]=1 even after 4 reads; after release, full[0]=0 and count[0]=4.
- Full lane with wr_en and rd_en together -> read returns the oldest word, write rejected, overflow set. Empty lane with both -> write accepted, no dout_valid.
- Assert rstn low mid-stream, and separately pulse flush with wr_en high -> all counts 0, flags cleared, dout_valid 0, no write stored; wrap test streams 20 words through 8 entries with no data loss.
